// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array operand feeder.
// Optional bubble counter is enabled by defining SYSTOLIC_FEEDER_BUBBLE_CNT_EN.
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // LSB position of lane `lane` in a packed lane vector of `dw`-bit lanes.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand/handshake bundle between a job source and the systolic feeder.
// bubble_cnt exists only when SYSTOLIC_FEEDER_BUBBLE_CNT_EN is defined.
interface systolic_feeder_if #(
  parameter int N  = systolic_pkg::N_DEF,
  parameter int DW = systolic_pkg::DW_DEF
);

  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [N*DW-1:0] in_a;
  logic [N*DW-1:0] in_b;
  logic [N*DW-1:0] a_row;
  logic [N*DW-1:0] b_col;
  logic            clear;
  logic            busy;
  logic            done;
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  modport master (
    output start, in_valid, in_last, in_a, in_b,
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    input  bubble_cnt,
`endif
    input  in_ready, a_row, b_col, clear, busy, done
  );

  modport slave (
    input  start, in_valid, in_last, in_a, in_b,
`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
    output bubble_cnt,
`endif
    output in_ready, a_row, b_col, clear, busy, done
  );

endinterface

// File: rtl/skew_delay.sv
// Fixed-depth shift register with synchronous reset; one instance per operand lane.
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: every stage is reset, not just the output one; a mid-job reset must
  // leave no stale operand in flight that would later reach the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Diagonal-skew operand feeder and job sequencer for an NxN output-stationary array.
// Define SYSTOLIC_FEEDER_BUBBLE_CNT_EN to add the saturating stall counter.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
);

  localparam int             DCW        = $clog2(2 * N);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * N - 2);

  state_e         state_q;
  logic [DCW-1:0] drain_q;
  logic           ready_q;
  logic           clear_q;
  logic           busy_q;
  logic           done_q;
  logic           accept;

  assign accept = bus.in_valid & ready_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
      ready_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= CLEAR;
          clear_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        CLEAR: begin
          state_q <= STREAM;
          ready_q <= 1'b1;
        end
        STREAM: if (accept && bus.in_last) begin
          state_q <= DRAIN;
          ready_q <= 1'b0;
          drain_q <= '0;
        end
        // Holds until the last beat has crossed the far-corner PE.
        DRAIN: if (drain_q == DRAIN_LAST) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          drain_q <= drain_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Lane i (A) and lane j (B) get i+1 / j+1 stages; non-accepted cycles feed zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay #(.DEPTH(i + 1), .WIDTH(DW)) u_a_skew (
      .clk (clk),
      .rst (rst),
      .d_i (accept ? bus.in_a[lane_lsb(i, DW) +: DW] : '0),
      .q_o (bus.a_row[lane_lsb(i, DW) +: DW])
    );
    skew_delay #(.DEPTH(i + 1), .WIDTH(DW)) u_b_skew (
      .clk (clk),
      .rst (rst),
      .d_i (accept ? bus.in_b[lane_lsb(i, DW) +: DW] : '0),
      .q_o (bus.b_col[lane_lsb(i, DW) +: DW])
    );
  end

  assign bus.in_ready = ready_q;
  assign bus.clear    = clear_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef SYSTOLIC_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_q, bubble_d;

  // NOTE: bubble_d takes a default before any branch so no latch is inferred.
  always_comb begin
    bubble_d = bubble_q;
    if (state_q == CLEAR) begin
      bubble_d = '0;
    end else if (state_q == STREAM && !accept && bubble_q != 16'hFFFF) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_q <= '0;
    else     bubble_q <= bubble_d;
  end

  assign bus.bubble_cnt = bubble_q;
`endif

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand skew feeder and job sequencer for the N×N output-stationary systolic MAC array. It accepts one K-step of operands per handshake: column k of A and row k of B. It drives the array's left edge (A rows) and top edge (B columns) with the diagonal skew the PEs require. It also issues the array-wide accumulator `clear` before a job and pulses `done` once the last product has been accumulated in the far-corner PE.

## Interface
- `N`, 4, array dimension (rows = columns = lanes)
- `DW`, 8, signed operand width per lane
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a job; honoured only in IDLE
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  feeder accepts beat (high only in STREAM)
- `in_last`  in  1  beat is the final K-step of the job
- `in_a`  in  N*DW  A[0..N-1][k], lane i at bits [i*DW +: DW]
- `in_b`  in  N*DW  B[k][0..N-1], lane j at bits [j*DW +: DW]
- `a_row`  out  N*DW  to PE(i,0) `a_in`, lane i
- `b_col`  out  N*DW  to PE(0,j) `b_in`, lane j
- `clear`  out  1  broadcast to all PEs' `clear`
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse: all accumulators final
- `bubble_cnt`  out  16  present only with `SYSTOLIC_FEEDER_BUBBLE_CNT_EN`

## Operation
- FSM states and transitions:
  - IDLE: `start` → CLEAR.
  - CLEAR: unconditional after 1 cycle → STREAM.
  - STREAM: accepted beat with `in_last` → DRAIN.
  - DRAIN: after 2N−1 cycles → DONE.
  - DONE: after 1 cycle → IDLE.
- `start` outside IDLE: ignored. `in_valid` outside STREAM: ignored; no beat is consumed.
- `in_ready` = (state == STREAM). A beat is accepted when `in_valid & in_ready`.
- Skew: lane i of A and lane j of B pass through i+1 and j+1 register stages respectively. All outputs are registered.
- Bubble handling: a STREAM cycle with no accepted beat injects zeros at the lane-0 stages. A zero product leaves the accumulators unchanged, so stalls are transparent to the result.
- In IDLE, CLEAR, DRAIN and DONE the lane-0 stages load zero, so the array is flushed with zeros.
- `clear` is high exactly during the CLEAR cycle. Edge outputs are zero in that cycle.
- Operands are passed through unmodified (signed DW). No arithmetic happens in the feeder.

## Timing
- Reset: `a_row`=0, `b_col`=0, `clear`=0, `done`=0, `busy`=0, `in_ready`=0, `bubble_cnt`=0, all skew registers=0, state=IDLE.
- `start` sampled at edge s: `clear` high in cycle s+1, `in_ready` high from cycle s+2.
- Beat accepted at edge t: lane i of `a_row` carries it in cycle t+1+i; lane j of `b_col` in cycle t+1+j.
- PE(i,j) sees beat t in cycle t+1+i+j.
- Last beat at edge t: DRAIN covers cycles t+1..t+2N−1, `done` is high in cycle t+2N (t+8 for N=4), and the state returns to IDLE in cycle t+2N+1.
- Minimum job: one beat. Back-to-back jobs: `start` may be asserted in the cycle after `done`.
- `rst` mid-job: all skew registers zero and state IDLE on the next edge. No `done` is issued. Accumulator contents are then undefined until the next CLEAR.

## Configuration
- `SYSTOLIC_FEEDER_BUBBLE_CNT_EN` defined:
  - `bubble_cnt` counts STREAM cycles with no accepted beat, saturating at 0xFFFF.
  - Zeroed on `rst` and in CLEAR; holds its value after `done`.
- Undefined: the port and counter are absent.

## Structure
- Shared package `systolic_pkg`:
  - FSM state enum (IDLE, CLEAR, STREAM, DRAIN, DONE)
  - default N/DW constants
  - lane-slice helper for packed `i*DW +: DW` indexing
- One sub-module `skew_delay`: parameterised depth and width shift register with synchronous reset, instantiated once per lane for A and for B.

## Test plan
- Skew: N=4, one beat `in_a`={1,2,3,4}, `in_b`={5,6,7,8}, `in_last`=1 at edge t → `a_row` lane i = i+1 in cycle t+1+i only; `b_col` lane j = j+5 in cycle t+1+j only; zeros otherwise.
- Full job with array: A=identity, B=[1..16] row-major, K=4 beats back-to-back → `done` exactly 8 cycles after the last acceptance; PE(i,j).c = B[i][j].
- Stalls: same job with `in_valid` low for 3 cycles between beats 2 and 3 → identical results; `done` 3 cycles later; `bubble_cnt`=3 (macro on).
- Clear: run a job, then a second job with A=0 → `clear` pulses in cycle s+1; all PE `c`=0 at `done`.
- `start` pulsed during STREAM/DRAIN → no state change, single `done`.
- `rst` asserted 2 cycles into DRAIN → next cycle all outputs 0 and `busy`=0; no `done` pulse follows.
